// File: rtl/xfer_seq_ctrl.sv
// Sequences one engine run per word of a control-register transfer and writes the done flag back.
// Optional WAIT timeout with a sticky error is built when XFER_TIMEOUT_EN is defined.
module xfer_seq_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       ctrl_in,
   output logic              wr2c,
   output logic              flag_o,
   output logic              new_o,
   output logic              eng_start,
   output logic [ADDR_W-1:0] eng_addr,
   input  logic              eng_done,
   output logic              busy,
   output logic              err,
   output logic [2:0]        state_dbg
);

   // No valid/ready handshake here: eng_start is a one-cycle request and
   // eng_done a one-cycle completion, honoured only while the FSM is in WAIT.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_NEXT   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] remaining;
   logic       timeout_hit;
   logic       unused_ctrl;

   assign unused_ctrl = ^{ctrl_in[31:16], ctrl_in[7:1]};
   assign state_dbg   = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         remaining <= 8'd0;
         eng_addr  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_LOAD: begin
               remaining <= ctrl_in[15:8];
               eng_addr  <= '0;
            end
            S_NEXT: begin
               if (remaining != 8'd0) begin
                  remaining <= remaining - 8'd1;
                  eng_addr  <= eng_addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef XFER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;

   // The counter is zeroed in START so it always begins at 0 on entry to WAIT.
   assign timeout_hit = (state == S_WAIT) && !eng_done &&
                        (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state == S_START)
            wait_cnt <= '0;
         else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
         if (state == S_LOAD)
            err <= 1'b0;
         else if (timeout_hit)
            err <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      wr2c      = 1'b0;
      flag_o    = 1'b0;
      new_o     = 1'b0;
      eng_start = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE:   if (ctrl_in[0]) state_nxt = S_LOAD;
         S_LOAD:   state_nxt = S_START;
         S_START: begin
            eng_start = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (eng_done)
               state_nxt = S_NEXT;
            else if (timeout_hit)
               state_nxt = S_FINISH;
         end
         S_NEXT:   state_nxt = (remaining == 8'd0) ? S_FINISH : S_START;
         S_FINISH: begin
            // err can only be set here by a timeout of this transfer, since LOAD cleared it.
            wr2c      = 1'b1;
            flag_o    = !err;
            new_o     = 1'b0;
            state_nxt = S_IDLE;
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_xfer_seq_ctrl.sv
// Self-checking bench for xfer_seq_ctrl: engine responder, control-register write-back model,
// address and write-back scoreboards. Timeout scenario runs when XFER_TIMEOUT_EN is defined.
module tb_xfer_seq_ctrl;

   localparam int ADDR_W  = 2;
   localparam int TIMEOUT = 8;

   logic              clk;
   logic              rst;
   logic [31:0]       ctrl_in;
   logic              wr2c;
   logic              flag_o;
   logic              new_o;
   logic              eng_start;
   logic [ADDR_W-1:0] eng_addr;
   logic              eng_done;
   logic              busy;
   logic              err;
   logic [2:0]        state_dbg;

   logic [ADDR_W-1:0] exp_q[$];
   logic [1:0]        wb_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int n_starts = 0;
   int resp_delay = 1;
   bit resp_spur = 0;
   bit resp_en = 1;

   xfer_seq_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .ctrl_in   (ctrl_in),
      .wr2c      (wr2c),
      .flag_o    (flag_o),
      .new_o     (new_o),
      .eng_start (eng_start),
      .eng_addr  (eng_addr),
      .eng_done  (eng_done),
      .busy      (busy),
      .err       (err),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // engine model: answers each eng_start after resp_delay cycles, optionally with a
   // spurious done coincident with eng_start
   always begin
      @(negedge clk);
      if (resp_en && eng_start) begin
         if (resp_spur) begin
            eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0;
            repeat (resp_delay - 1) @(negedge clk);
         end else begin
            repeat (resp_delay) @(negedge clk);
         end
         eng_done = 1'b1;
         @(negedge clk);
         eng_done = 1'b0;
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         if (eng_start) begin
            n_starts++;
            check_eq("start_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("eng_addr", eng_addr, exp_q.pop_front());
         end
         if (wr2c) begin
            check_eq("wb_expected", wb_q.size() != 0, 1);
            if (wb_q.size() != 0) check_eq("wb_flag_new", {flag_o, new_o}, wb_q.pop_front());
         end
      end
   end

   task automatic run_xfer(input int cnt, input int dly, input bit spur);
      int lat;
      bit seen;
      for (int i = 0; i <= cnt; i++) exp_q.push_back(ADDR_W'(i));
      wb_q.push_back(2'b10);
      resp_delay = dly;
      resp_spur  = spur;
      @(negedge clk);
      ctrl_in = {16'h0, 8'(cnt), 8'h01};
      lat  = 0;
      seen = 0;
      while (!seen && lat < 4000) begin
         @(negedge clk);
         lat++;
         if (lat == 2) begin
            check_eq("first_start_lat", eng_start, 1);
            check_eq("err_after_load", err, 0);
         end
         if (lat == 4) ctrl_in[15:8] = ~8'(cnt);
         if (wr2c) begin
            seen = 1;
            ctrl_in[1] = flag_o;
            ctrl_in[0] = new_o;
         end
      end
      check_eq("wb_latency", lat, 1 + (cnt + 1) * (2 + dly) + 1);
      @(negedge clk);
      check_eq("idle_after_wb", busy, 0);
      check_eq("addr_q_empty", exp_q.size(), 0);
   endtask

   initial begin
      int base;
      int lat;
      rst      = 1'b0;
      ctrl_in  = 32'h0000_0001;
      eng_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("reset_outs", {wr2c, flag_o, new_o, eng_start, busy, err, 6'(eng_addr)}, 0);
         check_eq("reset_state", state_dbg, 0);
      end
      ctrl_in = 32'h0;
      rst     = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_no_start", busy, 0);

      run_xfer(0, 1, 0);
      run_xfer(3, 1, 0);
      run_xfer(5, 2, 1);
      for (int k = 0; k < 4; k++)
         run_xfer($urandom_range(0, 9), $urandom_range(1, 4), 1'($urandom_range(0, 1)));

      // reset while waiting on the second word
      for (int i = 0; i < 2; i++) exp_q.push_back(ADDR_W'(i));
      resp_delay = 6;
      resp_spur  = 0;
      base = n_starts;
      @(negedge clk);
      ctrl_in = 32'h0000_0301;
      lat = 0;
      while (n_starts < base + 2 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check_eq("second_start_seen", n_starts - base, 2);
      @(negedge clk);
      check_eq("in_wait", state_dbg, 3);
      rst     = 1'b0;
      ctrl_in = 32'h0;
      @(negedge clk);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_addr", eng_addr, 0);
      check_eq("midrst_wr2c", wr2c, 0);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("midrst_q_empty", exp_q.size(), 0);
      check_eq("midrst_idle", state_dbg, 0);

`ifdef XFER_TIMEOUT_EN
      resp_en = 0;
      exp_q.push_back('0);
      wb_q.push_back(2'b00);
      @(negedge clk);
      ctrl_in = 32'h0000_0001;
      lat = 0;
      while (!wr2c && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      ctrl_in[1] = flag_o;
      ctrl_in[0] = new_o;
      check_eq("timeout_latency", lat, 2 + TIMEOUT + 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("err_sticky", err, 1);
      end
      check_eq("timeout_wb_empty", wb_q.size(), 0);
      resp_en = 1;
      run_xfer(1, 1, 0);
      check_eq("err_cleared", err, 0);
`else
      check_eq("err_tied_low", err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
